regfile_dual: RTL and testbench
===============================

REGFILE_DUAL -- requirements
Module: regfile_dual

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- we1  in  1  write enable, slot 1 (older instruction).
- waddr1  in  5  write address, slot 1.
- wdata1  in  32  write data, slot 1.
- we2  in  1  write enable, slot 2 (younger instruction).
- waddr2  in  5  write address, slot 2.
- wdata2  in  32  write data, slot 2.
- whilo  in  1  HI/LO write enable.
- hi_i  in  32  HI write data.
- lo_i  in  32  LO write data.
- raddr1..raddr4  in  5 each  read addresses: slot1 rs, slot1 rt, slot2 rs, slot2 rt.
- rdata1..rdata4  out  32 each  read data for raddr1..raddr4.
- hi_o  out  32  current HI value.
- lo_o  out  32  current LO value.

Function
REQ-002 SHALL hold 32 x 32-bit GPRs; register 0 SHALL always read 0, and writes to address 0 SHALL be discarded on both ports.
REQ-003 SHALL write wdata1 to GPR[waddr1] at the rising edge when we1=1 and rst=0.
REQ-004 SHALL write wdata2 to GPR[waddr2] at the rising edge when we2=1 and rst=0.
REQ-005 SHALL resolve we1=we2=1 with waddr1=waddr2 in favour of port 2 (younger wins); wdata1 SHALL be lost.
REQ-006 SHALL, for we1=we2=1 with different nonzero addresses, perform both writes at the same edge.
REQ-007 SHALL hold 32-bit HI and LO registers, both loaded from hi_i/lo_i at the rising edge when whilo=1 and rst=0; neither SHALL load alone.
REQ-008 SHALL provide combinational reads on rdata1..rdata4 with zero-cycle latency; all four ports SHALL be independent and may alias.
REQ-009 SHALL return 0 on every rdata port whose raddr is 0, regardless of bypass or pending writes.
REQ-010 SHALL drive hi_o/lo_o combinationally from the HI/LO registers, subject to REQ-015.
REQ-011 SHALL leave all state unchanged in any cycle with we1=we2=whilo=0.

Reset
REQ-012 SHALL clear all 32 GPRs, HI and LO to 0x00000000 at the rising edge with rst=1; any writes requested in that cycle SHALL be ignored.
REQ-013 SHALL drive rdata1..rdata4, hi_o and lo_o to 0 while rst=1, including with RF_BYPASS_EN defined.
REQ-014 SHALL leave state valid at the first edge with rst=0; a write in that cycle SHALL take effect.

Configuration
REQ-015 SHALL support macro RF_BYPASS_EN:
- Defined: a read of a nonzero address matching a same-cycle write returns the write data. Matches on both ports return wdata2. hi_o/lo_o return hi_i/lo_i when whilo=1.
- Undefined: reads return stored values only; writes become visible the cycle after the edge.

Verification
REQ-016 SHALL cover: rst=1 for 2 cycles, then raddr1..4=1,2,3,0 -> all rdata=0, hi_o=lo_o=0.
REQ-017 SHALL cover: we1=1, waddr1=5, wdata1=0x11111111 and we2=1, waddr2=5, wdata2=0x22222222 in one cycle; next cycle raddr1=5 -> rdata1=0x22222222.
REQ-018 SHALL cover: we1=1, waddr1=0, wdata1=0xDEADBEEF; next cycle raddr1..4=0 -> all 0.
REQ-019 SHALL cover: we2=1, waddr2=7, wdata2=0xCAFEF00D with raddr3=7 in the same cycle -> rdata3=0xCAFEF00D with RF_BYPASS_EN, previous GPR7 value without it; next cycle 0xCAFEF00D in both builds.
REQ-020 SHALL cover: whilo=1, hi_i=0x00000001, lo_i=0xFFFFFFFF for one cycle -> hi_o=0x00000001, lo_o=0xFFFFFFFF after the edge; then whilo=0 with new hi_i/lo_i -> values held.
REQ-021 SHALL cover: load GPR3=0x12345678, then rst=1 for one cycle together with we1=1, waddr1=3, wdata1=0xAAAAAAAA -> GPR3 reads 0 after reset.

Source files
------------

// File: rtl/regfile_dual.sv
// Dual-issue register file: 32x32 GPRs (r0 hardwired to zero), two write ports, four read ports, HI/LO pair.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to the read ports and hi_o/lo_o.
module regfile_dual (
  input  logic        clk,
  input  logic        rst,
  input  logic        we1,
  input  logic [4:0]  waddr1,
  input  logic [31:0] wdata1,
  input  logic        we2,
  input  logic [4:0]  waddr2,
  input  logic [31:0] wdata2,
  input  logic        whilo,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [4:0]  raddr3,
  input  logic [4:0]  raddr4,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] rdata3,
  output logic [31:0] rdata4,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] gpr [32];
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [4:0]  raddr [4];
  logic [31:0] rdata [4];

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;
  assign raddr[2] = raddr3;
  assign raddr[3] = raddr4;

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];
  assign rdata3 = rdata[2];
  assign rdata4 = rdata[3];

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is cleared on reset because software relies on every GPR starting at zero.
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      // Slot 2 is the younger instruction, so it takes priority on an address collision.
      for (int i = 1; i < 32; i++) begin
        if (we2 && waddr2 == 5'(i))      gpr[i] <= wdata2;
        else if (we1 && waddr1 == 5'(i)) gpr[i] <= wdata1;
      end
      if (whilo) begin
        hi_q <= hi_i;
        lo_q <= lo_i;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rdata[p] = '0;
      if (!rst && raddr[p] != 5'd0) begin
        rdata[p] = gpr[raddr[p]];
`ifdef RF_BYPASS_EN
        if (we2 && waddr2 == raddr[p])      rdata[p] = wdata2;
        else if (we1 && waddr1 == raddr[p]) rdata[p] = wdata1;
`endif
      end
    end
  end

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (!rst) begin
      hi_o = hi_q;
      lo_o = lo_q;
`ifdef RF_BYPASS_EN
      if (whilo) begin
        hi_o = hi_i;
        lo_o = lo_i;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_dual.sv
// Scoreboarded random + directed bench for regfile_dual; the reference model is a plain array updated per edge.
// Expectations follow RF_BYPASS_EN in the same way as the design build.
module tb_regfile_dual;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we1 = 1'b0, we2 = 1'b0, whilo = 1'b0;
  logic [4:0]  waddr1 = '0, waddr2 = '0;
  logic [31:0] wdata1 = '0, wdata2 = '0, hi_i = '0, lo_i = '0;
  logic [4:0]  raddr1 = '0, raddr2 = '0, raddr3 = '0, raddr4 = '0;
  logic [31:0] rdata1, rdata2, rdata3, rdata4, hi_o, lo_o;

  always #5 clk = ~clk;

  regfile_dual dut (
    .clk(clk), .rst(rst),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
    .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i),
    .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3), .raddr4(raddr4),
    .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3), .rdata4(rdata4),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct {
    logic        rst;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        we2;
    logic [4:0]  wa2;
    logic [31:0] wd2;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  ra [4];
  } stim_t;

  typedef struct {
    string       name;
    logic [31:0] rd [4];
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q [$];
  exp_t        mon_e;
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.we1 = 1'b0; s.wa1 = '0; s.wd1 = '0;
    s.we2 = 1'b0; s.wa2 = '0; s.wd2 = '0;
    s.whilo = 1'b0; s.hi = '0; s.lo = '0;
    for (int p = 0; p < 4; p++) s.ra[p] = '0;
    return s;
  endfunction

  function automatic logic [31:0] model_read(input stim_t s, input logic [4:0] a);
    if (s.rst || a == 5'd0) return '0;
`ifdef RF_BYPASS_EN
    if (s.we2 && s.wa2 == a) return s.wd2;
    if (s.we1 && s.wa1 == a) return s.wd1;
`endif
    return m_gpr[a];
  endfunction

  // Drive one cycle, queue the expected combinational outputs, then advance the model past the edge.
  task automatic apply(input stim_t s, input string name);
    exp_t e;
    @(posedge clk); #1;
    rst = s.rst; we1 = s.we1; waddr1 = s.wa1; wdata1 = s.wd1;
    we2 = s.we2; waddr2 = s.wa2; wdata2 = s.wd2;
    whilo = s.whilo; hi_i = s.hi; lo_i = s.lo;
    raddr1 = s.ra[0]; raddr2 = s.ra[1]; raddr3 = s.ra[2]; raddr4 = s.ra[3];
    e.name = name;
    for (int p = 0; p < 4; p++) e.rd[p] = model_read(s, s.ra[p]);
    e.hi = s.rst ? 32'h0 : m_hi;
    e.lo = s.rst ? 32'h0 : m_lo;
`ifdef RF_BYPASS_EN
    if (!s.rst && s.whilo) begin e.hi = s.hi; e.lo = s.lo; end
`endif
    sb_q.push_back(e);
    if (s.rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      m_hi = '0; m_lo = '0;
    end else begin
      if (s.we1 && s.wa1 != 5'd0) m_gpr[s.wa1] = s.wd1;
      if (s.we2 && s.wa2 != 5'd0) m_gpr[s.wa2] = s.wd2;
      if (s.whilo) begin m_hi = s.hi; m_lo = s.lo; end
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check({mon_e.name, ".rdata1"}, rdata1, mon_e.rd[0]);
      check({mon_e.name, ".rdata2"}, rdata2, mon_e.rd[1]);
      check({mon_e.name, ".rdata3"}, rdata3, mon_e.rd[2]);
      check({mon_e.name, ".rdata4"}, rdata4, mon_e.rd[3]);
      check({mon_e.name, ".hi_o"},   hi_o,   mon_e.hi);
      check({mon_e.name, ".lo_o"},   lo_o,   mon_e.lo);
    end
  end

  initial begin
    stim_t s;
    int    waited;
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_hi = '0; m_lo = '0;

    // Two reset cycles, then read 1,2,3,0 out of reset.
    s = idle(); s.rst = 1'b1; s.ra[0] = 5'd1; s.ra[1] = 5'd2; s.ra[2] = 5'd3; s.ra[3] = 5'd0;
    apply(s, "reset0");
    apply(s, "reset1");
    s.rst = 1'b0;
    apply(s, "post_reset");

    // Same-address dual write: younger slot wins.
    s = idle(); s.we1 = 1'b1; s.wa1 = 5'd5; s.wd1 = 32'h1111_1111;
    s.we2 = 1'b1; s.wa2 = 5'd5; s.wd2 = 32'h2222_2222;
    apply(s, "collide");
    s = idle(); s.ra[0] = 5'd5;
    apply(s, "collide_rd");

    // Writes to r0 are dropped.
    s = idle(); s.we1 = 1'b1; s.wa1 = 5'd0; s.wd1 = 32'hDEAD_BEEF;
    apply(s, "r0_wr");
    s = idle();
    apply(s, "r0_rd");

    // Same-cycle read of a write in flight, with a known prior value in GPR7.
    s = idle(); s.we1 = 1'b1; s.wa1 = 5'd7; s.wd1 = 32'h0000_0077;
    apply(s, "gpr7_init");
    s = idle(); s.we2 = 1'b1; s.wa2 = 5'd7; s.wd2 = 32'hCAFE_F00D; s.ra[2] = 5'd7;
    apply(s, "bypass");
    s = idle(); s.ra[2] = 5'd7;
    apply(s, "bypass_next");

    // Two different addresses written together.
    s = idle(); s.we1 = 1'b1; s.wa1 = 5'd9; s.wd1 = 32'h0909_0909;
    s.we2 = 1'b1; s.wa2 = 5'd10; s.wd2 = 32'h1010_1010;
    apply(s, "dual_wr");
    s = idle(); s.ra[0] = 5'd9; s.ra[1] = 5'd10; s.ra[2] = 5'd9; s.ra[3] = 5'd10;
    apply(s, "dual_rd");

    // HI/LO load, then hold with different inputs.
    s = idle(); s.whilo = 1'b1; s.hi = 32'h0000_0001; s.lo = 32'hFFFF_FFFF;
    apply(s, "hilo_ld");
    s = idle(); s.hi = 32'h5555_5555; s.lo = 32'hAAAA_AAAA;
    apply(s, "hilo_hold");
    apply(s, "hilo_hold2");

    // Reset overrides a write in the same cycle.
    s = idle(); s.we1 = 1'b1; s.wa1 = 5'd3; s.wd1 = 32'h1234_5678;
    apply(s, "gpr3_ld");
    s = idle(); s.ra[0] = 5'd3;
    apply(s, "gpr3_rd");
    s = idle(); s.rst = 1'b1; s.we1 = 1'b1; s.wa1 = 5'd3; s.wd1 = 32'hAAAA_AAAA; s.ra[0] = 5'd3;
    apply(s, "rst_vs_wr");
    s = idle(); s.ra[0] = 5'd3; s.ra[1] = 5'd7;
    apply(s, "gpr3_after_rst");

    // Random traffic on a narrow address range to provoke collisions and aliasing.
    for (int n = 0; n < 400; n++) begin
      s.rst   = ($urandom_range(0, 49) == 0);
      s.we1   = $urandom_range(0, 1);
      s.wa1   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      s.wd1   = $urandom;
      s.we2   = $urandom_range(0, 1);
      s.wa2   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      s.wd2   = $urandom;
      s.whilo = ($urandom_range(0, 3) == 0);
      s.hi    = $urandom;
      s.lo    = $urandom;
      for (int p = 0; p < 4; p++)
        s.ra[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      apply(s, "rand");
    end

    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
